// File: rtl/d_bch_enc_chunk_sequencer_pkg.sv
// d_bch_enc_chunk_sequencer_pkg: shared BCH encoder defaults, generator polynomial and FSM encodings
package d_bch_enc_chunk_sequencer_pkg;
    localparam int D_BCH_ENC_P_LVL      = 8;
    localparam int D_BCH_ENC_PRT_LENGTH = 168;
    localparam int D_BCH_ENC_MSG_CHUNKS = 256;
    // g(x) coefficients x^167..x^0; the x^168 term is implicit
    localparam logic [167:0] D_BCH_ENC_GEN = 168'hB54E219C7A03D6F1E82A5C90476BDE315F8C29A7E3;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PRT  = 2'd2
    } enc_state_t;
endpackage

// File: rtl/d_bch_enc_chunk_sequencer_lfs.sv
// d_parallel_m_lfs_XOR: advances the systematic-encoder remainder by P_LVL message bits, MSB first
module d_parallel_m_lfs_XOR
    import d_bch_enc_chunk_sequencer_pkg::*;
#(
    parameter int                    P_LVL      = D_BCH_ENC_P_LVL,
    parameter int                    PRT_LENGTH = D_BCH_ENC_PRT_LENGTH,
    parameter logic [PRT_LENGTH-1:0] GEN        = D_BCH_ENC_GEN[PRT_LENGTH-1:0]
) (
    input  logic [P_LVL-1:0]      i_message,
    input  logic [PRT_LENGTH-1:0] i_cur_parity,
    output logic [PRT_LENGTH-1:0] o_nxt_parity
);
    always_comb begin
        o_nxt_parity = i_cur_parity;
        for (int i = P_LVL - 1; i >= 0; i--)
            o_nxt_parity = {o_nxt_parity[PRT_LENGTH-2:0], 1'b0}
                         ^ ({PRT_LENGTH{i_message[i] ^ o_nxt_parity[PRT_LENGTH-1]}} & GEN);
    end
endmodule

// File: rtl/d_bch_enc_chunk_sequencer.sv
// d_bch_enc_chunk_sequencer: streams message chunks, then the BCH parity chunks, through one output register
module d_bch_enc_chunk_sequencer
    import d_bch_enc_chunk_sequencer_pkg::*;
#(
    parameter int P_LVL      = D_BCH_ENC_P_LVL,
    parameter int PRT_LENGTH = D_BCH_ENC_PRT_LENGTH,
    parameter int MSG_CHUNKS = D_BCH_ENC_MSG_CHUNKS
) (
    input  logic             i_clk,
    input  logic             i_RESET,
    input  logic             i_ENC_start,
    input  logic             i_message_valid,
    input  logic [P_LVL-1:0] i_message,
    output logic             o_message_ready,
    output logic             o_codeword_valid,
    output logic [P_LVL-1:0] o_codeword,
    output logic             o_codeword_type,
    output logic             o_codeword_last,
    input  logic             i_codeword_ready,
    output logic             o_busy
);
    localparam int PRT_CHUNKS = PRT_LENGTH / P_LVL;
    localparam int MW = MSG_CHUNKS > 1 ? $clog2(MSG_CHUNKS) : 1;
    localparam int PW = PRT_CHUNKS > 1 ? $clog2(PRT_CHUNKS) : 1;

    enc_state_t            state, state_nxt;
    logic [PRT_LENGTH-1:0] parity, parity_nxt;
    logic [MW-1:0]         msg_cnt;
    logic [PW-1:0]         prt_cnt;
    logic                  take, start, msg_acc, prt_load, msg_done, prt_done;

    d_parallel_m_lfs_XOR #(
        .P_LVL(P_LVL),
        .PRT_LENGTH(PRT_LENGTH),
        .GEN(D_BCH_ENC_GEN[PRT_LENGTH-1:0])
    ) u_lfs (
        .i_message(i_message),
        .i_cur_parity(parity),
        .o_nxt_parity(parity_nxt)
    );

    // the output register can take a new chunk when empty or being drained this cycle
    assign take            = !o_codeword_valid || i_codeword_ready;
    assign start           = state == IDLE && i_ENC_start;
    assign o_message_ready = state == MSG && take;
    assign msg_acc         = o_message_ready && i_message_valid;
    assign prt_load        = state == PRT && take;
    assign msg_done        = msg_acc && msg_cnt == MW'(MSG_CHUNKS - 1);
    assign prt_done        = prt_load && prt_cnt == PW'(PRT_CHUNKS - 1);
    assign o_busy          = state != IDLE;

    always_ff @(posedge i_clk or posedge i_RESET)
        if (i_RESET) state <= IDLE;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = start ? MSG : msg_done ? PRT : prt_done ? IDLE : state;
    end

    always_ff @(posedge i_clk or posedge i_RESET) begin
        if (i_RESET) begin
            parity           <= '0;
            msg_cnt          <= '0;
            prt_cnt          <= '0;
            o_codeword_valid <= 1'b0;
            o_codeword       <= '0;
            o_codeword_type  <= 1'b0;
            o_codeword_last  <= 1'b0;
        end else if (start) begin
            parity  <= '0;
            msg_cnt <= '0;
            prt_cnt <= '0;
        end else if (msg_acc) begin
            parity           <= parity_nxt;
            msg_cnt          <= msg_cnt + 1'b1;
            o_codeword_valid <= 1'b1;
            o_codeword       <= i_message;
            o_codeword_type  <= 1'b0;
            o_codeword_last  <= 1'b0;
        end else if (prt_load) begin
            parity           <= {parity[PRT_LENGTH-P_LVL-1:0], {P_LVL{1'b0}}};
            prt_cnt          <= prt_cnt + 1'b1;
            o_codeword_valid <= 1'b1;
            o_codeword       <= parity[PRT_LENGTH-1 -: P_LVL];
            o_codeword_type  <= 1'b1;
            o_codeword_last  <= prt_done;
        end else if (i_codeword_ready) begin
            o_codeword_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_d_bch_enc_chunk_sequencer.sv
// tb_d_bch_enc_chunk_sequencer: scoreboard bench for the BCH chunk sequencer
module tb_d_bch_enc_chunk_sequencer;
    import d_bch_enc_chunk_sequencer_pkg::*;
    localparam int P = 8, PL = 168, MC = 256, PC = PL / P;

    logic         clk = 0, rst = 1, start = 0, mvalid = 0, cready = 1;
    logic [P-1:0] mdata = '0;
    logic         mready, cvalid, ctype, clast, busy;
    logic [P-1:0] cdata;
    int           checks = 0, passed = 0;
    logic [9:0]   q[$];
    logic [P-1:0] msg[MC];
    logic [9:0]   held, cur;
    bit           held_v = 0;

    d_bch_enc_chunk_sequencer dut (
        .i_clk(clk), .i_RESET(rst), .i_ENC_start(start),
        .i_message_valid(mvalid), .i_message(mdata), .o_message_ready(mready),
        .o_codeword_valid(cvalid), .o_codeword(cdata), .o_codeword_type(ctype),
        .o_codeword_last(clast), .i_codeword_ready(cready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // bit-serial golden remainder; single=1 uses x^(MC*P-1+PL) mod g(x) directly
    task automatic push_expected(input bit single);
        logic [PL-1:0] r;
        logic          fb;
        r = '0;
        for (int c = 0; c < MC; c++) begin
            q.push_back({2'b00, msg[c]});
            for (int b = P - 1; b >= 0; b--) begin
                fb = msg[c][b] ^ r[PL-1];
                r  = {r[PL-2:0], 1'b0} ^ (fb ? D_BCH_ENC_GEN : '0);
            end
        end
        if (single) begin
            r = 1;
            for (int k = 0; k < MC * P - 1 + PL; k++)
                r = {r[PL-2:0], 1'b0} ^ (r[PL-1] ? D_BCH_ENC_GEN : '0);
        end
        for (int j = 0; j < PC; j++) q.push_back({1'b1, j == PC - 1, r[PL-1-P*j -: P]});
    endtask

    always @(negedge clk) begin
        cur = {ctype, clast, cdata};
        if (rst) held_v = 0;
        else if (cvalid) begin
            if (held_v) chk("hold_stable", 32'(cur), 32'(held));
            if (cready) begin
                held_v = 0;
                if (q.size() == 0) chk("spurious_valid", 32'(cvalid), 0);
                else chk($sformatf("chunk%0d", MC + PC - q.size()), 32'(cur), 32'(q.pop_front()));
            end else begin
                held   = cur;
                held_v = 1;
            end
        end
    end

    task automatic run_cw(input bit toggle, input bit pulses, input int abort_at, input bit single);
        bit acc;
        int i = 0, n = 0, guard = 0;
        push_expected(single);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        mvalid = 1;
        while (i < MC) begin
            mdata = msg[i];
            start = pulses && i == 50;
            if (i == abort_at) begin
                #2 rst = 1;
                #1 chk("reset_outputs", {cvalid, cdata, ctype, clast, mready, busy}, 0);
                q.delete();
                mvalid = 0;
                start  = 0;
                @(posedge clk); #1 rst = 0;
                return;
            end
            @(negedge clk) acc = mready;
            @(posedge clk); #1;
            if (acc) i++;
            if (toggle) cready = 1'($urandom_range(0, 1));
            if (++guard > 20 * MC) begin
                chk("msg_timeout", i, MC);
                break;
            end
        end
        mvalid = 0;
        start  = 0;
        while ((q.size() != 0 || cvalid) && n < 3000) begin
            start = pulses && n >= 3 && n < 6;
            @(posedge clk); #1 n++;
            if (toggle) cready = 1'($urandom_range(0, 1));
        end
        start = 0;
        chk("drain_done", q.size(), 0);
        @(posedge clk); #1 chk("idle_after", {busy, cvalid}, 0);
        cready = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_state", {cvalid, cdata, ctype, clast, mready, busy}, 0);
        rst = 0;
        foreach (msg[i]) msg[i] = '0;
        run_cw(0, 0, -1, 0);
        msg[0] = 8'h80;
        run_cw(0, 0, -1, 1);
        foreach (msg[i]) msg[i] = P'($urandom);
        run_cw(1, 0, -1, 0);
        run_cw(0, 0, -1, 0);
        foreach (msg[i]) msg[i] = P'($urandom);
        run_cw(0, 1, -1, 0);
        mvalid = 1;
        mdata  = 8'hA5;
        repeat (3) begin
            @(negedge clk) chk("idle_ignores_valid", {mready, busy, cvalid}, 0);
        end
        mvalid = 0;
        foreach (msg[i]) msg[i] = P'($urandom);
        run_cw(0, 0, 100, 0);
        run_cw(1, 0, -1, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
